// File: rtl/bin2bcd_pkg.sv
// Shared FSM encodings and sizing helpers for the sequential binary-to-BCD converter.
// min_digits() gives the digit count below which the overflow flag can fire.
package bin2bcd_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // Smallest d with 10^d >= 2^w, i.e. ceil(w*log10(2)).
  function automatic int min_digits(input int w);
    longint unsigned lim;
    longint unsigned p10;
    int d;
    lim = 64'd1 << w;
    p10 = 64'd1;
    d   = 0;
    for (int i = 0; i < 20; i++) begin
      if (p10 < lim) begin
        p10 = p10 * 64'd10;
        d   = d + 1;
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/bin2bcd_if.sv
// Operand and result handshakes of the binary-to-BCD converter.
// The slave side is the converter; the master side is its user.
interface bin2bcd_if #(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
);
  logic                  in_valid;
  logic                  in_ready;
  logic [BIN_W-1:0]      bin_in;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   bcd_out;
  logic                  out_neg;
  logic                  out_ovf;

  modport master (
    output in_valid, bin_in, out_ready,
    input  in_ready, out_valid, bcd_out, out_neg, out_ovf
  );

  modport slave (
    input  in_valid, bin_in, out_ready,
    output in_ready, out_valid, bcd_out, out_neg, out_ovf
  );
endinterface

// File: rtl/bcd_digit_adj.sv
// One BCD nibble of the double-dabble step: add 3 when the digit is 5 or more.
// Purely combinational, no handshake.
module bcd_digit_adj (
  input  logic [3:0] din,
  output logic [3:0] dout
);
  assign dout = (din >= 4'd5) ? din + 4'd3 : din;
endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD (shift-and-add-3), one operand bit per clock; result BIN_W+1 edges after accept.
// Accepts only when idle; the result is held stable until out_ready, with no input queueing.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5,
  parameter int SIGNED = 0
) (
  input logic       clk,
  input logic       rst_n,
  bin2bcd_if.slave  bus
);

  localparam int  CNT_W     = $clog2(BIN_W + 1);
  localparam int  BCD_W     = 4 * DIGITS;
  localparam bit  IS_SIGNED = (SIGNED != 0);
  localparam int  MIN_DIG   = min_digits(BIN_W);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [BIN_W-1:0] bin_sh;
  logic [BCD_W-1:0] acc;
  logic             ovf_acc;
  logic             neg_acc;
  logic             in_ready_r;
  logic             out_valid_r;
  logic [BCD_W-1:0] bcd_r;
  logic             neg_r;
  logic             ovf_r;

  logic [BCD_W-1:0] adj;
  logic [BCD_W-1:0] acc_next;
  logic             carry_out;
  logic             in_neg;
  logic [BIN_W-1:0] mag;

  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    bcd_digit_adj u_adj (
      .din  (acc[4*g +: 4]),
      .dout (adj[4*g +: 4])
    );
  end

  // A bit leaving the top digit means the value no longer fits in DIGITS digits.
  assign acc_next  = {adj[BCD_W-2:0], bin_sh[BIN_W-1]};
  assign carry_out = adj[BCD_W-1];

  // Two's-complement negation of the most negative value still fits as an unsigned magnitude.
  assign in_neg = IS_SIGNED && bus.bin_in[BIN_W-1];
  assign mag    = in_neg ? (~bus.bin_in + 1'b1) : bus.bin_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      bin_sh      <= '0;
      acc         <= '0;
      ovf_acc     <= 1'b0;
      neg_acc     <= 1'b0;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      bcd_r       <= '0;
      neg_r       <= 1'b0;
      ovf_r       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          in_ready_r <= 1'b1;
          if (bus.in_valid && in_ready_r) begin
            state      <= ST_SHIFT;
            in_ready_r <= 1'b0;
            bin_sh     <= mag;
            neg_acc    <= in_neg;
            acc        <= '0;
            ovf_acc    <= 1'b0;
            cnt        <= '0;
          end
        end
        ST_SHIFT: begin
          if (cnt == CNT_W'(BIN_W)) begin
            state       <= ST_DONE;
            out_valid_r <= 1'b1;
            bcd_r       <= ovf_acc ? {DIGITS{4'h9}} : acc;
            neg_r       <= neg_acc;
            ovf_r       <= ovf_acc;
          end else begin
            acc     <= acc_next;
            bin_sh  <= {bin_sh[BIN_W-2:0], 1'b0};
            ovf_acc <= ovf_acc | carry_out;
            cnt     <= cnt + CNT_W'(1);
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            state       <= ST_IDLE;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
          end
        end
        default: begin
          state      <= ST_IDLE;
          in_ready_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.bcd_out   = bcd_r;
  assign bus.out_neg   = neg_r;
  assign bus.out_ovf   = ovf_r;

  // With enough digits for the full operand range the flag must stay low.
  ovf_unreachable_a : assert property (@(posedge clk) disable iff (!rst_n)
    !(out_valid_r && ovf_r && (DIGITS >= MIN_DIG)));

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Bench for bin2bcd_seq: three configurations share one clock and reset,
// results are checked against an integer model through an expectation queue.
module tb_bin2bcd_seq;

  typedef struct {
    logic [19:0] bcd;
    logic        neg;
    logic        ovf;
  } exp_t;

  logic clk;
  logic rst_n;

  logic        vld  [3];
  logic [15:0] din  [3];
  logic        ordy [3];
  logic        rdy  [3];
  logic        ov   [3];
  logic [19:0] bcd  [3];
  logic        neg  [3];
  logic        ovf  [3];

  int   n_vec;
  int   n_err;
  exp_t exp_q[$];

  bin2bcd_if #(.BIN_W(16), .DIGITS(5)) if_a ();
  bin2bcd_if #(.BIN_W(16), .DIGITS(4)) if_b ();
  bin2bcd_if #(.BIN_W(8),  .DIGITS(3)) if_c ();

  bin2bcd_seq #(.BIN_W(16), .DIGITS(5), .SIGNED(0)) u_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
  bin2bcd_seq #(.BIN_W(16), .DIGITS(4), .SIGNED(0)) u_b (.clk(clk), .rst_n(rst_n), .bus(if_b));
  bin2bcd_seq #(.BIN_W(8),  .DIGITS(3), .SIGNED(1)) u_c (.clk(clk), .rst_n(rst_n), .bus(if_c));

  assign if_a.in_valid  = vld[0];
  assign if_a.bin_in    = din[0];
  assign if_a.out_ready = ordy[0];
  assign if_b.in_valid  = vld[1];
  assign if_b.bin_in    = din[1];
  assign if_b.out_ready = ordy[1];
  assign if_c.in_valid  = vld[2];
  assign if_c.bin_in    = din[2][7:0];
  assign if_c.out_ready = ordy[2];

  assign rdy[0] = if_a.in_ready;  assign ov[0] = if_a.out_valid;
  assign rdy[1] = if_b.in_ready;  assign ov[1] = if_b.out_valid;
  assign rdy[2] = if_c.in_ready;  assign ov[2] = if_c.out_valid;
  assign bcd[0] = if_a.bcd_out;
  assign bcd[1] = {4'h0, if_b.bcd_out};
  assign bcd[2] = {8'h00, if_c.bcd_out};
  assign neg[0] = if_a.out_neg;   assign ovf[0] = if_a.out_ovf;
  assign neg[1] = if_b.out_neg;   assign ovf[1] = if_b.out_ovf;
  assign neg[2] = if_c.out_neg;   assign ovf[2] = if_c.out_ovf;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int cfg_w(input int s);
    return (s == 2) ? 8 : 16;
  endfunction

  function automatic int cfg_d(input int s);
    return (s == 0) ? 5 : ((s == 1) ? 4 : 3);
  endfunction

  function automatic exp_t model(input logic [15:0] v, input int s);
    exp_t   e;
    longint mag;
    longint lim;
    int     w;
    w     = cfg_w(s);
    mag   = longint'(v) & ((longint'(1) << w) - 1);
    e.neg = 1'b0;
    if (s == 2 && ((mag >> (w - 1)) & 1) == 1) begin
      mag   = (longint'(1) << w) - mag;
      e.neg = 1'b1;
    end
    lim = 1;
    for (int i = 0; i < cfg_d(s); i++) lim = lim * 10;
    e.ovf = (mag >= lim);
    e.bcd = '0;
    for (int i = 0; i < cfg_d(s); i++) begin
      e.bcd[4*i +: 4] = e.ovf ? 4'h9 : 4'(mag % 10);
      mag = mag / 10;
    end
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one operand, wait for the result and compare it; leaves the result presented.
  task automatic xact(input int s, input logic [15:0] v);
    exp_t e;
    int   n;
    exp_q.push_back(model(v, s));
    n = 0;
    while (!rdy[s] && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", 32'(rdy[s]), 32'd1);
    din[s] = v;
    vld[s] = 1'b1;
    @(negedge clk);
    vld[s] = 1'b0;
    n = 0;
    while (!ov[s] && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("latency", 32'(n), 32'(cfg_w(s) + 1));
    e = exp_q.pop_front();
    check("bcd_out", 32'(bcd[s]), 32'(e.bcd));
    check("out_neg", 32'(neg[s]), 32'(e.neg));
    check("out_ovf", 32'(ovf[s]), 32'(e.ovf));
  endtask

  task automatic drain(input int s);
    ordy[s] = 1'b1;
    @(negedge clk);
    check("ready_after_hs", 32'(rdy[s]), 32'd1);
    check("valid_after_hs", 32'(ov[s]), 32'd0);
  endtask

  initial begin
    exp_t hold;
    n_vec = 0;
    n_err = 0;
    for (int i = 0; i < 3; i++) begin
      vld[i]  = 1'b0;
      din[i]  = '0;
      ordy[i] = 1'b1;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(rdy[0]), 32'd0);
    check("rst_out_valid", 32'(ov[0]), 32'd0);
    check("rst_bcd", 32'(bcd[0]), 32'd0);
    check("rst_neg", 32'(neg[2]), 32'd0);
    check("rst_ovf", 32'(ovf[1]), 32'd0);
    rst_n = 1'b1;
    #1;
    check("rdy_at_release", 32'(rdy[0]), 32'd0);
    @(negedge clk);
    check("rdy_first_edge", 32'(rdy[0]), 32'd1);

    // Directed vectors for each configuration.
    xact(0, 16'd0);     drain(0);
    xact(0, 16'd65535); drain(0);
    xact(0, 16'd40960); drain(0);
    xact(1, 16'd12345); drain(1);
    xact(1, 16'd9999);  drain(1);
    xact(2, 16'h0080);  drain(2);
    xact(2, 16'h00FF);  drain(2);
    xact(2, 16'h007F);  drain(2);
    xact(2, 16'h0000);  drain(2);

    // Backpressure: result must hold and new operands must be ignored.
    hold    = model(16'd31337, 0);
    ordy[0] = 1'b0;
    xact(0, 16'd31337);
    for (int i = 0; i < 10; i++) begin
      vld[0] = (i % 2 == 0);
      din[0] = 16'($urandom);
      @(negedge clk);
      check("bp_valid", 32'(ov[0]), 32'd1);
      check("bp_bcd", 32'(bcd[0]), 32'(hold.bcd));
      check("bp_in_ready", 32'(rdy[0]), 32'd0);
    end
    vld[0] = 1'b0;
    drain(0);
    repeat (3) @(negedge clk);
    check("bp_no_accept", 32'(ov[0]), 32'd0);
    check("bp_bcd_retained", 32'(bcd[0]), 32'(hold.bcd));

    // Reset in the middle of a conversion.
    din[0] = 16'd12345;
    vld[0] = 1'b1;
    @(negedge clk);
    vld[0] = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(ov[0]), 32'd0);
    check("midrst_bcd", 32'(bcd[0]), 32'd0);
    check("midrst_ready", 32'(rdy[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    xact(0, 16'd42); drain(0);

    for (int i = 0; i < 1000; i++) begin
      int s;
      s = int'($urandom_range(0, 2));
      xact(s, 16'($urandom));
      drain(s);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
